// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// CAUSE register layout and the request/acknowledge state encoding.
// Pure declarations, no logic.
package interrupt_controller_pkg;

  // Byte offsets of the memory-mapped registers relative to BASE.
  localparam int PENDING_OFF = 0;
  localparam int MASK_OFF    = 4;
  localparam int CAUSE_OFF   = 8;
  localparam int CTRL_OFF    = 12;

  // Bit of the CAUSE read value that flags a request or service in progress.
  localparam int CAUSE_VALID_BIT = 8;

  // Handshake with the processor: no request, request raised, handler running.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/Register.sv
// Generic write-enabled storage register with synchronous reset to zero.
// Latency: d_i visible on q_o one clk edge after we_i.
// Backpressure: none, a write is always accepted.
//
// Ports:
//   clk_i   - clock
//   reset_i - synchronous active-high reset
//   we_i    - load enable
//   d_i     - load data
//   q_o     - stored value
module Register #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else if (we_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: lowest set bit of the request vector wins.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   vec_i - request vector, bit i = source i
//   any_o - at least one bit of vec_i is set
//   idx_o - index of the lowest set bit (0 when vec_i is zero)
module irq_priority_enc #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  vec_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    // Scan from the top down so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt aggregator: edge-latched pending bits, mask, global
// enable, prioritised single request with ack/done handshake (no nesting).
// Latency: device edge -> pending at next edge -> intReq one edge later; no backpressure.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   we, re, memAddr     - bus write/read strobes and address
//   dataBusIn           - bus write data
//   dataBusOut          - bus read data, zero unless this block is being read
//   devIrq              - device interrupt levels (ready & IE), bit i = source i
//   intAck, intDone     - processor took the interrupt / finished the handler
//   intReq, intCause    - registered request and source index to the processor
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int              N_SRC = 4,
  parameter int              BITS  = 32,
  parameter logic [BITS-1:0] BASE  = 32'hF0000040,
  localparam int             CW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [BITS-1:0]  memAddr,
  input  logic [BITS-1:0]  dataBusIn,
  input  logic [N_SRC-1:0] devIrq,
  input  logic             intAck,
  input  logic             intDone,
  output logic             intReq,
  output logic [CW-1:0]    intCause,
  output logic [BITS-1:0]  dataBusOut
);

  // ---------------------------------------------------------------- decode
  logic sel_pend, sel_mask, sel_cause, sel_ctrl;

  assign sel_pend  = (memAddr == BASE + BITS'(PENDING_OFF));
  assign sel_mask  = (memAddr == BASE + BITS'(MASK_OFF));
  assign sel_cause = (memAddr == BASE + BITS'(CAUSE_OFF));
  assign sel_ctrl  = (memAddr == BASE + BITS'(CTRL_OFF));

  logic wr_pend, wr_mask, wr_ctrl;
  logic rd_pend, rd_mask, rd_cause, rd_ctrl;
  logic rd_en;

  assign rd_en    = re & ~we;
  assign wr_pend  = we & sel_pend;
  assign wr_mask  = we & sel_mask;
  assign wr_ctrl  = we & sel_ctrl;
  assign rd_pend  = rd_en & sel_pend;
  assign rd_mask  = rd_en & sel_mask;
  assign rd_cause = rd_en & sel_cause;
  assign rd_ctrl  = rd_en & sel_ctrl;

  // Upper write-data bits have no storage behind them.
  logic unused_wdata;
  assign unused_wdata = ^dataBusIn[BITS-1:N_SRC];

  // ------------------------------------------------------- mask / control
  logic [N_SRC-1:0] mask_q;
  logic             gie_q;

  Register #(.WIDTH(N_SRC)) u_mask_reg (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (wr_mask),
    .d_i     (dataBusIn[N_SRC-1:0]),
    .q_o     (mask_q)
  );

  Register #(.WIDTH(1)) u_ctrl_reg (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (wr_ctrl),
    .d_i     (dataBusIn[0]),
    .q_o     (gie_q)
  );

  // -------------------------------------------------------------- pending
  irq_state_t       state_q;
  logic             int_req_q;
  logic [CW-1:0]    int_cause_q;
  logic [N_SRC-1:0] prev_irq_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] irq_rise, w1c_clr, ack_clr;

  assign irq_rise = devIrq & ~prev_irq_q;
  assign w1c_clr  = wr_pend ? dataBusIn[N_SRC-1:0] : '0;

  always_comb begin
    ack_clr = '0;
    if (state_q == ST_REQ && intAck) begin
      ack_clr[int_cause_q] = 1'b1;
    end
  end

  // Set is applied after the clears so a same-cycle edge is never lost.
  assign pending_d = (pending_q & ~w1c_clr & ~ack_clr) | irq_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      prev_irq_q <= '0;
    end else begin
      pending_q  <= pending_d;
      prev_irq_q <= devIrq;
    end
  end

  // ------------------------------------------------------------- priority
  logic          enc_any;
  logic [CW-1:0] enc_idx;

  irq_priority_enc #(.N(N_SRC), .IW(CW)) u_prio (
    .vec_i (pending_q & mask_q),
    .any_o (enc_any),
    .idx_o (enc_idx)
  );

  // ------------------------------------------------------------ handshake
  // intReq/intCause are only loaded on the IDLE->REQ transition, which is
  // what freezes them against mask/GIE/pending changes while in REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      int_req_q   <= 1'b0;
      int_cause_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gie_q && enc_any) begin
            state_q     <= ST_REQ;
            int_req_q   <= 1'b1;
            int_cause_q <= enc_idx;
          end
        end
        ST_REQ: begin
          if (intAck) begin
            state_q   <= ST_SERVICE;
            int_req_q <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (intDone) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          int_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign intReq   = int_req_q;
  assign intCause = int_cause_q;

  // ------------------------------------------------------------ read data
  always_comb begin
    dataBusOut = '0;
    if (rd_pend) begin
      dataBusOut[N_SRC-1:0] = pending_q;
    end
    if (rd_mask) begin
      dataBusOut[N_SRC-1:0] = mask_q;
    end
    if (rd_cause) begin
      dataBusOut[CW-1:0]            = int_cause_q;
      dataBusOut[CAUSE_VALID_BIT]   = (state_q == ST_REQ) || (state_q == ST_SERVICE);
    end
    if (rd_ctrl) begin
      dataBusOut[0] = gie_q;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the register
// map and the request/ack/done protocol.
module tb_interrupt_controller;

  localparam logic [31:0] A_PEND  = 32'hF0000040;
  localparam logic [31:0] A_MASK  = 32'hF0000044;
  localparam logic [31:0] A_CAUSE = 32'hF0000048;
  localparam logic [31:0] A_CTRL  = 32'hF000004C;
  localparam logic [31:0] A_OTHER = 32'hF0000050;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, re;
  logic [31:0] memAddr, dataBusIn;
  logic [3:0]  devIrq;
  logic        intAck, intDone;
  logic        intReq;
  logic [1:0]  intCause;
  logic [31:0] dataBusOut;

  interrupt_controller dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .re         (re),
    .memAddr    (memAddr),
    .dataBusIn  (dataBusIn),
    .devIrq     (devIrq),
    .intAck     (intAck),
    .intDone    (intDone),
    .intReq     (intReq),
    .intCause   (intCause),
    .dataBusOut (dataBusOut)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  bit [3:0] m_pend, m_mask, m_prev;
  bit       m_gie;
  bit       m_waiting;   // request raised, not yet acknowledged
  bit       m_in_isr;    // handler running
  int       m_cause;

  function automatic int lowest(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] v = 0;
    if (a == A_PEND)  v = {28'd0, m_pend};
    if (a == A_MASK)  v = {28'd0, m_mask};
    if (a == A_CTRL)  v = {31'd0, m_gie};
    if (a == A_CAUSE) v = 32'(m_cause) + ((m_waiting || m_in_isr) ? 32'h100 : 32'h0);
    return v;
  endfunction

  task automatic model_step();
    bit [3:0] np;
    if (reset) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_gie = 0;
      m_waiting = 0; m_in_isr = 0; m_cause = 0;
      return;
    end
    np = m_pend;
    if (we && memAddr == A_PEND) np = np & ~dataBusIn[3:0];
    if (m_waiting && intAck) np[m_cause] = 1'b0;
    np = np | (devIrq & ~m_prev);
    if (m_waiting) begin
      if (intAck) begin m_waiting = 0; m_in_isr = 1; end
    end else if (m_in_isr) begin
      if (intDone) m_in_isr = 0;
    end else if (m_gie && (m_pend & m_mask) != 0) begin
      m_waiting = 1;
      m_cause   = lowest(m_pend & m_mask);
    end
    if (we && memAddr == A_MASK) m_mask = dataBusIn[3:0];
    if (we && memAddr == A_CTRL) m_gie  = dataBusIn[0];
    m_pend = np;
    m_prev = devIrq;
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic tick();
    #1;
    chk_eq("rdata", dataBusOut, (re && !we) ? m_read(memAddr) : 32'd0);
    model_step();
    @(posedge clk);
    #1;
    chk_eq("intReq", {31'd0, intReq}, {31'd0, m_waiting});
    chk_eq("intCause", {30'd0, intCause}, 32'(m_cause));
    @(negedge clk);
    we = 0; re = 0; intAck = 0; intDone = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1; memAddr = a; dataBusIn = d;
    tick();
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    re = 1; memAddr = a;
    #1;
    chk_eq(tag, dataBusOut, exp);
    tick();
  endtask

  initial begin
    reset = 1; we = 0; re = 0; memAddr = 0; dataBusIn = 0;
    devIrq = 0; intAck = 0; intDone = 0;
    @(negedge clk);
    tick(); tick();
    reset = 0;
    chk_eq("rst_req", {31'd0, intReq}, 32'd0);
    chk_eq("rst_cause", {30'd0, intCause}, 32'd0);
    rd("rst_pend", A_PEND, 32'h0);

    // Single source, latency and CAUSE layout.
    wr(A_MASK, 32'h6);
    wr(A_CTRL, 32'h1);
    devIrq = 4'b0100; tick();
    rd("s1_pend", A_PEND, 32'h4);
    chk_eq("s1_req", {31'd0, intReq}, 32'd1);
    chk_eq("s1_cause", {30'd0, intCause}, 32'd2);
    rd("s1_causereg", A_CAUSE, 32'h102);
    devIrq = 0; intAck = 1; tick();
    intDone = 1; tick();

    // Two simultaneous sources: lowest first, second after return.
    wr(A_MASK, 32'hF);
    devIrq = 4'b0110; tick();
    tick();
    chk_eq("s2_cause1", {30'd0, intCause}, 32'd1);
    intAck = 1; tick();
    chk_eq("s2_req_ack", {31'd0, intReq}, 32'd0);
    rd("s2_pend", A_PEND, 32'h4);
    devIrq = 0; intDone = 1; tick();
    tick();
    chk_eq("s2_req2", {31'd0, intReq}, 32'd1);
    chk_eq("s2_cause2", {30'd0, intCause}, 32'd2);
    intAck = 1; tick();
    intDone = 1; tick();

    // Masked source, unmasking, W1C in IDLE.
    wr(A_MASK, 32'h7);
    devIrq = 4'b1000; tick();
    tick();
    rd("s3_pend", A_PEND, 32'h8);
    chk_eq("s3_masked", {31'd0, intReq}, 32'd0);
    wr(A_MASK, 32'h8);
    tick();
    chk_eq("s3_req", {31'd0, intReq}, 32'd1);
    chk_eq("s3_cause", {30'd0, intCause}, 32'd3);
    intAck = 1; tick();
    intDone = 1; tick();
    wr(A_CTRL, 32'h0);
    devIrq = 0; tick();
    devIrq = 4'b1000; tick();
    rd("s3_pend2", A_PEND, 32'h8);
    wr(A_PEND, 32'h8);
    rd("s3_w1c", A_PEND, 32'h0);
    devIrq = 0;

    // W1C colliding with a fresh edge: set wins.
    wr(A_MASK, 32'h0);
    devIrq = 4'b0001; tick();
    devIrq = 4'b0000; tick();
    devIrq = 4'b0001; wr(A_PEND, 32'h1);
    rd("s4_setwins", A_PEND, 32'h1);
    devIrq = 0; wr(A_PEND, 32'h1);

    // REQ frozen against mask/GIE changes; stray ack/done ignored.
    wr(A_CTRL, 32'h1);
    wr(A_MASK, 32'h4);
    devIrq = 4'b0100; tick();
    tick();
    wr(A_MASK, 32'h0);
    wr(A_CTRL, 32'h0);
    tick();
    chk_eq("s5_hold_req", {31'd0, intReq}, 32'd1);
    chk_eq("s5_hold_cause", {30'd0, intCause}, 32'd2);
    intAck = 1; tick();
    intAck = 1; tick();
    chk_eq("s5_stray_ack", {31'd0, intReq}, 32'd0);
    rd("s5_svc_cause", A_CAUSE, 32'h102);
    intDone = 1; tick();
    intDone = 1; tick();
    rd("s5_idle_cause", A_CAUSE, 32'h002);
    devIrq = 0;

    // Reset in SERVICE with pending bits outstanding.
    wr(A_CTRL, 32'h1);
    wr(A_MASK, 32'hF);
    devIrq = 4'b1010; tick();
    tick();
    intAck = 1; tick();
    devIrq = 4'b1000; tick();
    devIrq = 4'b1010; tick();
    rd("s6_pend", A_PEND, 32'hA);
    reset = 1; devIrq = 4'b0001; tick();
    reset = 0;
    chk_eq("s6_req", {31'd0, intReq}, 32'd0);
    chk_eq("s6_cause", {30'd0, intCause}, 32'd0);
    rd("s6_causereg", A_CAUSE, 32'h0);
    rd("s6_pend_rel", A_PEND, 32'h1);
    rd("s6_mask", A_MASK, 32'h0);
    rd("s6_ctrl", A_CTRL, 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] addrs [5];
      addrs[0] = A_PEND; addrs[1] = A_MASK; addrs[2] = A_CAUSE;
      addrs[3] = A_CTRL; addrs[4] = A_OTHER;
      reset = ($urandom_range(0, 199) == 0);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) devIrq[b] = ~devIrq[b];
      we        = ($urandom_range(0, 7) == 0);
      re        = ($urandom_range(0, 2) == 0);
      memAddr   = addrs[$urandom_range(0, 4)];
      dataBusIn = $urandom;
      if (memAddr == A_CTRL && $urandom_range(0, 3) != 0) dataBusIn[0] = 1'b1;
      intAck    = m_waiting ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      intDone   = m_in_isr  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      tick();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Memory-mapped interrupt aggregator that sits directly downstream of the I/O devices (switches, keys, timer).
- Consumes each device's interrupt line (device ready AND its IE control bit) and latches it into a pending register.
- Applies a mask and a global enable, then presents a single prioritised interrupt request plus a cause index to the processor.
- Runs a request/acknowledge/done handshake with the processor; nesting is not supported.

Parameters:
- N_SRC, 4, number of interrupt sources; 1..BITS-1.
- BITS, 32, bus and register width.
- BASE, 32'hF0000040, address of PENDING; MASK = BASE+4, CAUSE = BASE+8, CTRL = BASE+12.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- we  in  1  bus write enable.
- re  in  1  bus read enable.
- memAddr  in  BITS  bus address.
- dataBusIn  in  BITS  write data.
- devIrq  in  N_SRC  device interrupt levels; bit i = source i.
- intAck  in  1  processor has taken the interrupt (1-cycle pulse).
- intDone  in  1  processor finished the handler (1-cycle pulse, return-from-interrupt).
- intReq  out  1  interrupt request to the processor; registered.
- intCause  out  log2(N_SRC) (min 1)  index of the requested/in-service source; registered.
- dataBusOut  out  BITS  read data; 0 when no read of this block is in progress.

Behaviour:
- Bus write = we & address match. Bus read = re & !we & address match. Read data is combinational from current register state.
- Reset: pending, mask, GIE, prevIrq, intReq, intCause all 0; state = IDLE.
- Edge detect: prevIrq <= devIrq every cycle. At each edge, pending[i] is set if devIrq[i] & !prevIrq[i]. Because prevIrq resets to 0, a source already high at reset release posts pending on the first cycle after release.
- PENDING register:
  - Read returns {0, pending}.
  - Write is write-1-to-clear.
  - A set from an edge in the same cycle as a clear (by W1C or by ack) of the same bit: set wins.
- MASK register: read/write, low N_SRC bits. 1 = enabled.
- CTRL register: bit0 = GIE, read/write; other bits read 0.
- CAUSE register: read returns {0, valid(bit8), intCause}. valid = 1 while state is REQ or SERVICE.
- State machine:
  - IDLE: when GIE and (pending & mask) != 0, go to REQ. Latch intCause = lowest set index of (pending & mask). intReq <= 1.
  - REQ: intReq held at 1 and intCause frozen until intAck, even if the mask, GIE or pending changes meanwhile. On intAck, clear pending[intCause], set intReq <= 0, go to SERVICE.
  - SERVICE: intReq = 0 and new requests are blocked. On intDone, go to IDLE. The next request may assert on the cycle after return to IDLE (one idle cycle minimum).
  - intAck outside REQ and intDone outside SERVICE are ignored.
- Latency: devIrq rises before edge k → pending set at edge k → intReq high after edge k+1.
- Reset mid-operation (REQ or SERVICE) returns to IDLE with everything cleared; in-flight pending bits are lost.
- Arithmetic: the priority encode is a fixed lowest-index-first scan. No counters wrap.

Decomposition:
- Shared package holds:
  - Register offsets (PENDING_OFF = 0, MASK_OFF = 4, CAUSE_OFF = 8, CTRL_OFF = 12).
  - The CAUSE valid bit position (8).
  - The 2-bit state encoding (IDLE, REQ, SERVICE).
- One sub-module, irq_priority_enc: N_SRC-bit vector in, outputs any and lowest-set index; purely combinational.
- The existing Register module is reused for MASK and CTRL storage.

Test Plan:
- Reset, MASK = 4'b0110, GIE = 1. Pulse devIrq[2] at edge k → pending = 4'b0100 at k; intReq = 1 and intCause = 2 after k+1; CAUSE reads 0x102.
- devIrq[1] and devIrq[2] rise in the same cycle, all sources masked in → intCause = 1. intAck → pending = 4'b0100 and intReq = 0. intDone → IDLE; after one cycle intReq = 1 with intCause = 2.
- devIrq[3] rises with MASK[3] = 0 → pending[3] = 1 and intReq stays 0. Write MASK = 4'b1000 → intReq = 1 with intCause = 3 two edges later. Write PENDING = 4'b1000 in IDLE → bit clears.
- W1C of PENDING bit0 in the same cycle as a devIrq[0] rising edge → pending[0] remains 1.
- In REQ with intCause = 2, write MASK = 0 and GIE = 0 → intReq stays 1 and intCause stays 2 until intAck. Stray intAck in SERVICE and intDone in IDLE cause no state change.
- Assert reset while in SERVICE with pending = 4'b1010 → next cycle all registers 0, intReq = 0, CAUSE reads 0; devIrq[0] held high → pending[0] = 1 on the first edge after reset release.
